// File: rtl/scope_capture_ctrl.sv
// Scope capture sequencer: waits for a level crossing (or an auto-trigger
// timeout) on the incoming sample stream, writes one decimated frame of
// NUM_SAMPLES samples into the display RAM, then holds it until the display
// acknowledges it.
//
// Interface timing: a sample is accepted on a rising clk_20k edge where
// sample_valid is high. A low sample_valid stalls every counter. There is no
// backpressure: the RAM write port takes wr_en/wr_addr/wr_data whenever
// wr_en is high (a one-cycle pulse, one cycle after the accepted sample).
// frame_ready stays high until a frame_ack seen in HOLD.
module scope_capture_ctrl #(
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 10,
  parameter int NUM_SAMPLES = 640,
  parameter int DECIM_W     = 8,
  parameter int AUTO_TMO    = 20000
) (
  input  logic               clk_20k,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  sample_in,
  input  logic               sample_valid,
  input  logic               arm,
  input  logic               abort,
  input  logic               freeze,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic               trig_edge,
  input  logic               auto_en,
  input  logic [DECIM_W-1:0] decim,
  input  logic               frame_ack,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               frame_ready,
  output logic               auto_trig,
  output logic [1:0]         state
);

  localparam int TMO_W = $clog2(AUTO_TMO + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TMO - 1);
  localparam logic [TMO_W-1:0]  TMO_SAT   = TMO_W'(AUTO_TMO);
  // A one-sample frame is complete with the trigger write itself.
  localparam bit SINGLE_SAMPLE = (NUM_SAMPLES == 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               prev_valid_q, prev_valid_d;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [DECIM_W-1:0] decim_lat_q, decim_lat_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               frame_ready_q, frame_ready_d;
  logic               auto_trig_q, auto_trig_d;

  logic               rise_x;
  logic               fall_x;
  logic               crossing;
  logic               tmo_hit;
  logic [ADDR_W-1:0]  next_addr;

  // Trigger detection against the previous valid sample seen while ARMED.
  always_comb begin
    rise_x    = (prev_q < trig_level) && (sample_in >= trig_level);
    fall_x    = (prev_q > trig_level) && (sample_in <= trig_level);
    crossing  = prev_valid_q && (trig_edge ? rise_x : fall_x);
    // tmo_cnt_q counts valid samples already seen in ARMED, so the current
    // one is the AUTO_TMO-th when the count has reached AUTO_TMO-1.
    tmo_hit   = auto_en && (tmo_cnt_q >= TMO_LAST);
    next_addr = wr_addr_q + 1'b1;
  end

  // Next-state and registered-output computation; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    prev_valid_d  = prev_valid_q;
    prev_d        = prev_q;
    tmo_cnt_d     = tmo_cnt_q;
    dec_cnt_d     = dec_cnt_q;
    decim_lat_d   = decim_lat_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_ready_d = frame_ready_q;
    auto_trig_d   = auto_trig_q;

    if (abort) begin
      state_d       = S_IDLE;
      frame_ready_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d      = S_ARMED;
            prev_valid_d = 1'b0;
            tmo_cnt_d    = '0;
          end
        end

        S_ARMED: begin
          if (sample_valid) begin
            prev_d       = sample_in;
            prev_valid_d = 1'b1;
            // Saturate so a long wait with auto_en low never wraps.
            if (tmo_cnt_q != TMO_SAT) begin
              tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
            if (crossing || tmo_hit) begin
              // The trigger sample is the first sample of the frame.
              auto_trig_d   = !crossing;
              wr_en_d       = 1'b1;
              wr_addr_d     = '0;
              wr_data_d     = sample_in;
              decim_lat_d   = decim;
              dec_cnt_d     = decim;
              state_d       = SINGLE_SAMPLE ? S_HOLD : S_CAPTURE;
              frame_ready_d = SINGLE_SAMPLE;
            end
          end
        end

        S_CAPTURE: begin
          if (sample_valid) begin
            if (dec_cnt_q == '0) begin
              wr_en_d   = 1'b1;
              wr_addr_d = next_addr;
              wr_data_d = sample_in;
              dec_cnt_d = decim_lat_q;
              if (next_addr == LAST_ADDR) begin
                state_d       = S_HOLD;
                frame_ready_d = 1'b1;
              end
            end else begin
              dec_cnt_d = dec_cnt_q - 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (frame_ack) begin
            frame_ready_d = 1'b0;
            if (freeze) begin
              state_d = S_IDLE;
            end else begin
              state_d      = S_ARMED;
              prev_valid_d = 1'b0;
              tmo_cnt_d    = '0;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_20k or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      prev_valid_q  <= 1'b0;
      prev_q        <= '0;
      tmo_cnt_q     <= '0;
      dec_cnt_q     <= '0;
      decim_lat_q   <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_ready_q <= 1'b0;
      auto_trig_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_valid_q  <= prev_valid_d;
      prev_q        <= prev_d;
      tmo_cnt_q     <= tmo_cnt_d;
      dec_cnt_q     <= dec_cnt_d;
      decim_lat_q   <= decim_lat_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_ready_q <= frame_ready_d;
      auto_trig_q   <= auto_trig_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_ready = frame_ready_q;
  assign auto_trig   = auto_trig_q;
  assign state       = state_q;

endmodule
